pic_fetch_ctrl: RTL and testbench



---
 rtl/pic_pkg.sv | 34 +++
 rtl/pic_ret_stack.sv | 42 ++++
 rtl/pic_fetch_ctrl.sv | 110 +++++++++++
 tb/tb_pic_fetch_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared constants and types for the 12-bit PIC instruction-fetch path.
// Opcode match values are compared against the top bits of the instruction word.
package pic_pkg;

  localparam int PC_W        = 9;
  localparam int INSTR_W     = 12;
  localparam int STACK_DEPTH = 2;

  localparam logic [INSTR_W-1:0] NOP_WORD = 12'h000;

  localparam logic [2:0] OP_GOTO  = 3'b101;   // matched on [11:9]
  localparam logic [3:0] OP_CALL  = 4'b1001;  // matched on [11:8]
  localparam logic [3:0] OP_RETLW = 4'b1000;  // matched on [11:8]

  typedef enum logic {
    ST_FILL,
    ST_RUN
  } fetch_state_e;

  typedef enum logic [1:0] {
    OPC_OTHER,
    OPC_GOTO,
    OPC_CALL,
    OPC_RETLW
  } ctrl_op_e;

  function automatic ctrl_op_e decode_ctrl(input logic [INSTR_W-1:0] word);
    if (word[11:9] == OP_GOTO)       return OPC_GOTO;
    else if (word[11:8] == OP_CALL)  return OPC_CALL;
    else if (word[11:8] == OP_RETLW) return OPC_RETLW;
    else                             return OPC_OTHER;
  endfunction

endpackage

// File: rtl/pic_ret_stack.sv
// Two-level hardware return stack: shift-register push/pop, saturating depth
// counter and a sticky overflow flag raised by a push into a full stack.
module pic_ret_stack
  import pic_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [PC_W-1:0] i_din,
  output logic [PC_W-1:0] o_top,
  output logic            o_ovf
);

  logic [PC_W-1:0] r_stack [STACK_DEPTH];
  logic [1:0]      r_depth;
  logic            r_ovf;

  // NOTE: the stack entries are ordinary flops, not a RAM, so they take the
  // async reset like any other state; a pop from an empty stack must read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stack[0] <= '0;
      r_stack[1] <= '0;
      r_depth    <= '0;
      r_ovf      <= 1'b0;
    end else if (i_push) begin
      r_stack[1] <= r_stack[0];
      r_stack[0] <= i_din;
      if (r_depth == 2'(STACK_DEPTH)) r_ovf <= 1'b1;
      else                            r_depth <= r_depth + 2'd1;
    end else if (i_pop) begin
      // Bottom entry is duplicated, not cleared, so repeated pops keep returning it.
      r_stack[0] <= r_stack[1];
      if (r_depth != 2'd0) r_depth <= r_depth - 2'd1;
    end
  end

  assign o_top = r_stack[0];
  assign o_ovf = r_ovf;

endmodule

// File: rtl/pic_fetch_ctrl.sv
// Fetch sequencer: owns the PC, registers the ROM word into execute, resolves
// GOTO/CALL/RETLW and ALU skips with a single NOP bubble each.
module pic_fetch_ctrl #(
  parameter logic [pic_pkg::PC_W-1:0]    RESET_VECTOR = 9'd0,
  parameter logic [pic_pkg::INSTR_W-1:0] NOP_WORD     = pic_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [8:0]  rom_addr,
  input  logic [11:0] rom_data,
  input  logic        stall,
  input  logic        skip_req,
  output logic [11:0] instr,
  output logic        instr_valid,
  output logic [8:0]  ex_pc,
  output logic [7:0]  retlw_lit,
  output logic        stack_ovf
);

  import pic_pkg::*;

  fetch_state_e          r_state;
  logic [PC_W-1:0]       r_pc;
  logic [INSTR_W-1:0]    r_instr;
  logic                  r_valid;
  logic [PC_W-1:0]       r_ex_pc;

  ctrl_op_e              w_op;
  logic                  w_push;
  logic                  w_pop;
  logic [PC_W-1:0]       w_top;
  logic [PC_W-1:0]       w_pc_inc;

  // Bubbles never decode, so a squashed word can't redirect the PC.
  assign w_op     = r_valid ? decode_ctrl(r_instr) : OPC_OTHER;
  assign w_pc_inc = r_pc + 9'd1;
  assign w_push   = !stall && (r_state == ST_RUN) && (w_op == OPC_CALL);
  assign w_pop    = !stall && (r_state == ST_RUN) && (w_op == OPC_RETLW);

  pic_ret_stack u_stack (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_din  (r_pc),
    .o_top  (w_top),
    .o_ovf  (stack_ovf)
  );

  // NOTE: all state here is updated with non-blocking assignments so every
  // branch reads the pre-edge PC and instruction, never a half-updated value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FILL;
      r_pc    <= RESET_VECTOR;
      r_instr <= NOP_WORD;
      r_valid <= 1'b0;
      r_ex_pc <= '0;
    end else if (!stall) begin
      unique case (r_state)
        ST_FILL: begin
          r_instr <= rom_data;
          r_valid <= 1'b1;
          r_ex_pc <= r_pc;
          r_pc    <= w_pc_inc;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          unique case (w_op)
            OPC_GOTO: begin
              r_pc    <= r_instr[8:0];
              r_instr <= NOP_WORD;
              r_valid <= 1'b0;
            end
            OPC_CALL: begin
              r_pc    <= {1'b0, r_instr[7:0]};
              r_instr <= NOP_WORD;
              r_valid <= 1'b0;
            end
            OPC_RETLW: begin
              r_pc    <= w_top;
              r_instr <= NOP_WORD;
              r_valid <= 1'b0;
            end
            OPC_OTHER: begin
              if (r_valid && skip_req) begin
                // Drop the prefetched word and move past it.
                r_pc    <= w_pc_inc;
                r_instr <= NOP_WORD;
                r_valid <= 1'b0;
              end else begin
                r_instr <= rom_data;
                r_valid <= 1'b1;
                r_ex_pc <= r_pc;
                r_pc    <= w_pc_inc;
              end
            end
          endcase
        end
      endcase
    end
  end

  assign rom_addr    = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign ex_pc       = r_ex_pc;
  assign retlw_lit   = (w_op == OPC_RETLW) ? r_instr[7:0] : 8'd0;

endmodule

// File: tb/tb_pic_fetch_ctrl.sv
// Self-checking bench for pic_fetch_ctrl: directed scenarios plus randomized
// ROM images, stalls and skips, all compared against an instruction-level model.
module tb_pic_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  rom_addr;
  logic [11:0] rom_data;
  logic        stall;
  logic        skip_req;
  logic [11:0] instr;
  logic        instr_valid;
  logic [8:0]  ex_pc;
  logic [7:0]  retlw_lit;
  logic        stack_ovf;

  logic [11:0] rom [512];

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  int unsigned m_pc, m_instr, m_ex, m_depth;
  int unsigned m_stk [2];
  bit          m_valid, m_filled, m_ovf;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  pic_fetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .stall       (stall),
    .skip_req    (skip_req),
    .instr       (instr),
    .instr_valid (instr_valid),
    .ex_pc       (ex_pc),
    .retlw_lit   (retlw_lit),
    .stack_ovf   (stack_ovf)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_goto(input int unsigned w);  return (w >> 9) == 5; endfunction
  function automatic bit is_call(input int unsigned w);  return (w >> 8) == 9; endfunction
  function automatic bit is_retlw(input int unsigned w); return (w >> 8) == 8; endfunction

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_ex = 0; m_valid = 0; m_filled = 0;
    m_stk[0] = 0; m_stk[1] = 0; m_depth = 0; m_ovf = 0;
  endtask

  task automatic model_bubble();
    m_instr = 0;
    m_valid = 0;
  endtask

  // One clock of the fetch rules, at instruction level.
  task automatic model_edge();
    if (!rst_n || stall) return;
    if (!m_filled || !(m_valid && (is_goto(m_instr) || is_call(m_instr) ||
                                   is_retlw(m_instr) || skip_req))) begin
      m_instr  = rom[m_pc];
      m_valid  = 1;
      m_ex     = m_pc;
      m_pc     = (m_pc + 1) % 512;
      m_filled = 1;
    end else if (is_goto(m_instr)) begin
      m_pc = m_instr % 512;
      model_bubble();
    end else if (is_call(m_instr)) begin
      m_stk[1] = m_stk[0];
      m_stk[0] = m_pc;
      if (m_depth == 2) m_ovf = 1;
      else              m_depth++;
      m_pc = m_instr % 256;
      model_bubble();
    end else if (is_retlw(m_instr)) begin
      m_pc     = m_stk[0];
      m_stk[0] = m_stk[1];
      if (m_depth > 0) m_depth--;
      model_bubble();
    end else begin
      m_pc = (m_pc + 1) % 512;
      model_bubble();
    end
  endtask

  task automatic compare_all();
    int unsigned exp_lit;
    exp_lit = (m_valid && is_retlw(m_instr)) ? (m_instr % 256) : 0;
    check("rom_addr", rom_addr, m_pc);
    check("instr_valid", instr_valid, m_valid);
    check("instr", instr, m_instr);
    if (m_valid) check("ex_pc", ex_pc, m_ex);
    check("retlw_lit", retlw_lit, exp_lit);
    check("stack_ovf", stack_ovf, m_ovf);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run_until_ex(input int unsigned addr, input int budget);
    int n = 0;
    while (!(m_valid && m_ex == addr) && n < budget) begin
      tick();
      n++;
    end
    if (!(m_valid && m_ex == addr)) check("wait_ex_timeout", n, budget + 1);
  endtask

  task automatic fill_rom_plain();
    for (int i = 0; i < 512; i++) rom[i] = 12'($urandom_range(0, 12'h7FF));
  endtask

  // Hold reset across an edge, then release between edges.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen6;
    rst_n = 1'b0; stall = 1'b0; skip_req = 1'b0;
    model_reset();

    // Program image: sequential start, skip at 30, GOTO at 31 and 40
    fill_rom_plain();
    rom[0] = 12'hC09; rom[1] = 12'h028; rom[30] = 12'h743;
    rom[31] = 12'hA25; rom[37] = 12'hC08; rom[40] = 12'hA1F;
    #2;
    compare_all();
    check("rst_ex_pc", ex_pc, 0);
    #10 rst_n = 1'b1;
    tick();
    check("fill_addr", rom_addr, 1);
    check("fill_instr", instr, 12'hC09);
    check("fill_valid", instr_valid, 1);
    check("fill_ex_pc", ex_pc, 0);
    tick();
    check("seq_addr", rom_addr, 2);
    check("seq_instr", instr, 12'h028);
    check("seq_ex_pc", ex_pc, 1);

    run_until_ex(30, 60);
    skip_req = 1'b1;
    tick();
    skip_req = 1'b0;
    check("skip_bubble", instr_valid, 0);
    tick();
    check("skip_next_ex", ex_pc, 32);
    check("skip_next_valid", instr_valid, 1);

    run_until_ex(31, 60);
    tick();
    check("goto_addr", rom_addr, 9'h025);
    check("goto_bubble", instr_valid, 0);
    tick();
    check("goto_instr", instr, 12'hC08);
    check("goto_ex_pc", ex_pc, 37);

    // Nested calls with overflow, then returns
    rst_n = 1'b0;
    model_reset();
    fill_rom_plain();
    rom[0] = 12'hA05; rom[5] = 12'h910; rom[9'h10] = 12'h920;
    rom[9'h20] = 12'h930; rom[9'h30] = 12'h855; rom[9'h21] = 12'h8AA;
    do_reset();
    seen6 = 0;
    for (int n = 0; n < 80 && !(m_valid && m_ex == 9'h30); n++) begin
      tick();
      if (instr_valid && ex_pc == 9'd6) seen6 = 1;
    end
    check("retlw_reached", ex_pc, 9'h30);
    check("retlw_lit_55", retlw_lit, 8'h55);
    check("call_ovf", stack_ovf, 1);
    tick();
    check("ret1_addr", rom_addr, 9'h021);
    run_until_ex(9'h21, 10);
    tick();
    check("ret2_addr", rom_addr, 9'h011);
    for (int n = 0; n < 40; n++) begin
      tick();
      if (instr_valid && ex_pc == 9'd6) seen6 = 1;
    end
    check("never_ret_to_6", seen6, 0);

    // PC wrap-around
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 512; i++) rom[i] = 12'h000;
    rom[2] = 12'hBFE;
    do_reset();
    run_until_ex(2, 10);
    tick();
    check("wrap_addr_1fe", rom_addr, 9'h1FE);
    tick();
    check("wrap_addr_1ff", rom_addr, 9'h1FF);
    tick();
    check("wrap_addr_000", rom_addr, 9'h000);
    check("wrap_ex_1ff", ex_pc, 9'h1FF);
    tick();
    check("wrap_instr", instr, 12'h000);
    check("wrap_valid", instr_valid, 1);
    check("wrap_ex_0", ex_pc, 0);

    // Stall over a GOTO, then reset mid-stall
    rst_n = 1'b0;
    model_reset();
    fill_rom_plain();
    rom[0] = 12'hA40; rom[9'h40] = 12'h950; rom[9'h50] = 12'h960;
    do_reset();
    tick();
    stall = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("stall_addr", rom_addr, 1);
      check("stall_instr", instr, 12'hA40);
      check("stall_valid", instr_valid, 1);
    end
    stall = 1'b0;
    tick();
    check("stall_goto_addr", rom_addr, 9'h040);
    check("stall_goto_bubble", instr_valid, 0);
    run_until_ex(9'h60, 20);
    stall = 1'b1;
    tick();
    #3;
    rst_n = 1'b0;
    model_reset();
    rom[0] = 12'h800;
    #1;
    compare_all();
    check("rst_stall_addr", rom_addr, 0);
    check("rst_stall_valid", instr_valid, 0);
    stall = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("stack_cleared", rom_addr, 0);

    // Randomized images, stalls, skips and occasional async resets
    for (int r = 0; r < 6; r++) begin
      rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < 512; i++) rom[i] = 12'($urandom);
      stall = 1'b0; skip_req = 1'b0;
      do_reset();
      for (int n = 0; n < 400; n++) begin
        stall    = ($urandom_range(0, 7) == 0);
        skip_req = ($urandom_range(0, 3) == 0);
        tick();
        if (r % 2 == 1 && n == 200) begin
          rst_n = 1'b0;
          model_reset();
          #1;
          compare_all();
          rst_n = 1'b1;
        end
      end
    end
    stall = 1'b0; skip_req = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
